instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction decoder.
//  - Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
//  - Buffers in-order responses in a small FIFO and presents {instruction, pc} to decode over valid/ready.
//  - A redirect (branch/jump/trap) flushes buffered and in-flight fetches and restarts at the new PC.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH      2              instruction buffer entries (>=1)
//  MAX_OUTSTANDING 2              max accepted-but-unanswered imem requests (>=1)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   reset: synchronous, active-high
//  redirect_valid  in   1   restart fetch at redirect_pc this cycle
//  redirect_pc     in   32  redirect target
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address of request (bits[1:0]=0)
//  imem_rsp_valid  in   1   response valid; in order, one per accepted request, never backpressured
//  imem_rsp_data   in   32  fetched instruction word
//  if_valid        out  1   instruction available to decode
//  if_ready        in   1   decode consumes instruction
//  if_instr        out  32  instruction word (decoder input)
//  if_pc           out  32  PC of if_instr
//  if_misalign     out  1   only with FETCH_MISALIGN_CHK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - pc_q=RESET_PC, rsp_pc=RESET_PC.
//   - FIFO empty; inflight=0; drop_cnt=0.
//   - imem_req_valid=0 and if_valid=0 while rst=1.
//   - Reset mid-operation discards all state; responses to pre-reset requests must not arrive after reset (memory is reset together).
//  Request issue:
//   - imem_req_valid = !rst && !redirect_valid && inflight<MAX_OUTSTANDING && (fifo_count+inflight-drop_cnt)<FIFO_DEPTH.
//   - imem_req_addr=pc_q. Accept when valid&&ready: pc_q+=4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
//   - imem_req_valid may drop without acceptance (no request stickiness required by memory).
//  Response:
//   - inflight +1 on accept, -1 on imem_rsp_valid (both same cycle: unchanged).
//   - If drop_cnt>0: response discarded, drop_cnt-1.
//   - Else push {imem_rsp_data, rsp_pc} into FIFO, rsp_pc+=4.
//   - Credit rule guarantees no push when full; a push to a full FIFO is an assertion failure.
//  Output:
//   - if_valid = FIFO non-empty && !redirect_valid; if_instr/if_pc = head entry.
//   - Pop on if_valid&&if_ready; push and pop in the same cycle are both performed.
//   - Latency: response -> if_valid 1 cycle; redirect -> first imem_req_valid 1 cycle later.
//   - Head stable while if_valid&&!if_ready.
//  Redirect (highest priority after rst):
//   - FIFO cleared; no pop completes that cycle; no request issued; response that cycle discarded.
//   - pc_q=rsp_pc={redirect_pc[31:2],2'b00}.
//   - drop_cnt = inflight - imem_rsp_valid (all remaining in-flight responses discarded).
//   - Back-to-back redirects: last one wins; drop_cnt recomputed each time.
//  Throughput: with zero-wait memory, if_ready=1 and no redirects: one instruction per cycle, sustained.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined:
//   - On redirect with redirect_pc[1:0]!=0, a misalign flag is latched.
//   - The first instruction delivered after that redirect presents if_misalign=1, then the flag clears.
//   - Flag clears on reset or on any later redirect with aligned target.
//   - if_misalign=0 otherwise.
//  FETCH_MISALIGN_CHK_EN undefined:
//   - if_misalign port absent; low target bits silently forced to 0.
// TESTING
//  - Reset, zero-wait mem, if_ready=1 -> addrs 0x0,0x4,0x8..; if_pc matches; one instruction/cycle after 2-cycle startup.
//  - if_ready=0 for 10 cycles -> exactly FIFO_DEPTH responses buffered, imem_req_valid=0; release -> in-order delivery, no loss or duplicate.
//  - 2 requests in flight (3-cycle latency), redirect_pc=0x100 -> both stale responses dropped; first if_pc=0x100, if_instr=mem[0x100].
//  - Redirect in same cycle as imem_rsp_valid and if_ready=1 -> no pop, response dropped, drop_cnt=inflight-1; next delivery is target.
//  - redirect_pc=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst mid-stream -> next addr RESET_PC, if_valid=0.
//  - MACRO on: redirect_pc=0x102 -> fetch 0x100, first output if_misalign=1, next 0; MACRO off: same fetch, no flag.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC, issues word fetches over a valid/ready request channel, and
// buffers in-order responses in a small FIFO presented to decode as
// {if_instr, if_pc}. A redirect flushes the buffer, marks every in-flight
// response for discard and restarts fetch at the aligned target.
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds the if_misalign output,
// flagging the first instruction delivered after a redirect whose target had
// non-zero low bits. Without it the low target bits are silently dropped.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        if_misalign
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [31:0] FIFO_DEPTH_L = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAX_OUT_L    = 32'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q;
    logic [31:0]      rsp_pc;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [OUT_W-1:0] inflight;
    logic [OUT_W-1:0] drop_cnt;

    logic [31:0] target_pc;
    logic [31:0] credit_used;
    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        push;
    logic        pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);

    // Entries already buffered plus responses still owed that will be kept;
    // drop_cnt never exceeds inflight, so this cannot underflow.
    assign credit_used = 32'(fifo_count) + 32'(inflight) - 32'(drop_cnt);

    assign imem_req_valid = !rst && !redirect_valid
                            && (32'(inflight) < MAX_OUT_L)
                            && (credit_used < FIFO_DEPTH_L);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response is kept only outside reset/redirect and once all stale ones are gone.
    assign push = !rst && imem_rsp_valid && !redirect_valid && (drop_cnt == '0);

    assign if_valid = !rst && !fifo_empty && !redirect_valid;
    assign if_instr = fifo_instr[rd_ptr];
    assign if_pc    = fifo_pc[rd_ptr];
    assign pop      = if_valid && if_ready;

    // Fetch PC: restarts on redirect, advances on every accepted request (wraps mod 2^32).
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= target_pc;
        end else if (accept) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // PC tagged onto the next kept response; follows the same restart point as pc_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rsp_pc <= target_pc;
        end else if (push) begin
            rsp_pc <= rsp_pc + 32'd4;
        end
    end

    // Outstanding-request count: +1 on accept, -1 on any response (kept or dropped).
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({accept, imem_rsp_valid})
                2'b10:   inflight <= inflight + OUT_W'(1);
                2'b01:   inflight <= inflight - OUT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Stale-response counter: a redirect marks everything still owed after this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            if (imem_rsp_valid && (inflight != '0)) begin
                drop_cnt <= inflight - OUT_W'(1);
            end else begin
                drop_cnt <= inflight;
            end
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - OUT_W'(1);
        end
    end

    // Buffer control: pointers and occupancy; redirect empties it in one cycle.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Buffer storage: data only, no reset needed since validity lives in fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Misalign flag: set by an unaligned redirect, cleared once that first instruction is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= (redirect_pc[1:0] != 2'b00);
        end else if (pop) begin
            misalign_q <= 1'b0;
        end
    end

    assign if_misalign = misalign_q && if_valid;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

`ifndef SYNTHESIS
    // The credit check on requests must make a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full))
                else $error("instr_fetch_unit: response pushed into full buffer");
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable in-order
// memory model and a scoreboard of expected {pc, instr, misalign} deliveries.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam int          MAX_OUT    = 2;
`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit MIS_ON = 1'b1;
`else
    localparam bit MIS_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    instr_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .if_misalign   (if_misalign)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr;
    int          nvec = 0;
    int          nmis = 0;
    int          deliveries = 0;
    int          accepts = 0;
    int          lat = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // In-order memory: lat==0 answers combinationally, otherwise after lat cycles.
    logic        pv [4];
    logic [31:0] pa [4];
    logic        rsp_v;
    logic [31:0] rsp_a;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= imem_req_valid && imem_req_ready;
            pa[0] <= imem_req_addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    always_comb begin
        rsp_v = 1'b0;
        rsp_a = 32'h0;
        if (lat == 0) begin
            rsp_v = imem_req_valid && imem_req_ready;
            rsp_a = imem_req_addr;
        end else begin
            rsp_v = pv[lat-1];
            rsp_a = pa[lat-1];
        end
    end

    assign imem_rsp_valid = rsp_v;
    assign imem_rsp_data  = rsp_v ? mem_word(rsp_a) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
            else begin
                nmis++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard load: the stream the DUT must deliver starting at target t.
    task automatic expect_from(input logic [31:0] t);
        exp_t e;
        sb.delete();
        exp_addr = {t[31:2], 2'b00};
        for (int k = 0; k < 96; k++) begin
            e.pc    = exp_addr + 32'(4 * k);
            e.instr = mem_word(e.pc);
            e.mis   = MIS_ON && (k == 0) && (t[1:0] != 2'b00);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        lat = l;
        expect_from(RESET_PC);
        step();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic wait_deliv(input string tag, input int n, input int budget);
        int d0;
        d0 = deliveries;
        for (int c = 0; c < budget; c++) begin
            step();
            if (deliveries - d0 >= n) break;
        end
        chk(tag, 32'(deliveries - d0 >= n), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        expect_from(t);
    endtask

    // Request monitor: every accepted address must follow the model PC.
    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            accepts++;
        end
    end

    // Delivery monitor: pop the scoreboard on each decode handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if_valid && if_ready) begin
            deliveries++;
            if (sb.size() == 0) begin
                nvec++;
                assert (sb.size() != 0)
                    else begin
                        nmis++;
                        $error("FAIL sb_underflow: observed pc %h, expected no delivery", if_pc);
                    end
            end else begin
                e = sb.pop_front();
                chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.instr);
`ifdef FETCH_MISALIGN_CHK_EN
                chk("if_misalign", 32'(if_misalign), 32'(e.mis));
`endif
            end
        end
    end

    initial begin
        int d0;
        int a0;
        bit found;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        lat            = 0;
        expect_from(RESET_PC);

        // Reset and zero-wait streaming
        do_reset(0);
        #1;
        chk("start_req_valid", 32'(imem_req_valid), 32'd1);
        chk("start_req_addr", imem_req_addr, RESET_PC);
        chk("start_if_valid", 32'(if_valid), 32'd0);
        step();
        chk("first_if_valid", 32'(if_valid), 32'd1);
        step();
        d0 = deliveries;
        repeat (20) step();
        chk("throughput", 32'(deliveries - d0), 32'd20);

        // Decode stall: buffer fills, requests stop, then in-order drain
        if_ready = 1'b0;
        repeat (10) step();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        d0 = deliveries;
        repeat (FIFO_DEPTH + 3) step();
        chk("buffered_count", 32'(deliveries - d0), 32'(FIFO_DEPTH));
        chk("drained_if_valid", 32'(if_valid), 32'd0);
        imem_req_ready = 1'b1;
        d0 = deliveries;
        repeat (8) step();
        chk("resume_count", 32'(deliveries - d0), 32'd7);

        // Redirect with two requests outstanding at 3-cycle latency
        do_reset(3);
        step();
        step();
        chk("full_inflight_req_valid", 32'(imem_req_valid), 32'd0);
        do_redirect(32'h0000_0100);
        step();
        redirect_valid = 1'b0;
        wait_deliv("redirect_lat3_deliv", 3, 30);

        // Redirect colliding with a response and a ready decode
        do_reset(1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (imem_rsp_valid && if_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("collision_found", 32'(found), 32'd1);
        do_redirect(32'h0000_0200);
        #1;
        chk("redir_if_valid", 32'(if_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        wait_deliv("redirect_collide_deliv", 4, 30);

        // Address wrap, then reset mid-stream
        do_reset(0);
        repeat (3) step();
        do_redirect(32'hFFFF_FFF8);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
        a0 = accepts;
        repeat (4) step();
        chk("wrap_accepts", 32'(accepts - a0), 32'd4);
        rst = 1'b1;
        expect_from(RESET_PC);
        #1;
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("postrst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("postrst_req_addr", imem_req_addr, RESET_PC);
        chk("postrst_if_valid", 32'(if_valid), 32'd0);
        wait_deliv("postrst_deliv", 3, 20);

        // Unaligned redirect target
        do_redirect(32'h0000_0102);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("misalign_req_addr", imem_req_addr, 32'h0000_0100);
        wait_deliv("misalign_deliv", 3, 20);

        // Random handshakes on both channels at 2-cycle latency
        do_reset(2);
        for (int c = 0; c < 60; c++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            if_ready       = 1'($urandom_range(0, 1));
            step();
        end
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        wait_deliv("random_tail_deliv", 4, 30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
